// File: rtl/host_mode_seq.sv
// Safe run-time host-mode switch: drain TX, idle FTDI pins, pulse core reset, apply new mode.
// Latency: done 2*GUARD_CYCLES+RST_CYCLES+3 cycles after strobe with immediate drain; no-op/reject in 1.
// Backpressure: accept_en low while switching; strobes arriving mid-sequence park in a one-deep slot.
module host_mode_seq #(
    parameter logic [1:0] DEF_MODE      = 2'b00,
    parameter int         GUARD_CYCLES  = 16,
    parameter int         RST_CYCLES    = 4,
    parameter int         DRAIN_TIMEOUT = 1024,
    parameter int         CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_mode,
    input  logic       req_strobe,
    input  logic       tx_fifo_empty,
    input  logic       if_busy,
    output logic [1:0] host_mode,
    output logic       inactive_io,
    output logic       if_reset,
    output logic       accept_en,
    output logic       busy,
    output logic       done,
    output logic       mode_err,
    output logic       drain_to
);

    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_QUIESCE,
        S_CORE_RST,
        S_APPLY,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       target;
    logic             pend_vld;
    logic [1:0]       pend_mode;
    logic [1:0]       nxt_mode;
    logic             cnt_zero;

    // A fresh strobe in IDLE overrides anything left in the pending slot.
    always_comb begin
        nxt_mode = pend_mode;
        if (req_strobe) nxt_mode = req_mode;
    end

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            target      <= DEF_MODE;
            pend_vld    <= 1'b0;
            pend_mode   <= 2'b00;
            host_mode   <= DEF_MODE;
            inactive_io <= 1'b0;
            if_reset    <= 1'b0;
            accept_en   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            mode_err    <= 1'b0;
            drain_to    <= 1'b0;
        end else begin
            done     <= 1'b0;
            mode_err <= 1'b0;

            if (req_strobe && state != S_IDLE) begin
                pend_vld  <= 1'b1;
                pend_mode <= req_mode;
            end

            case (state)
                S_IDLE: begin
                    if (req_strobe || pend_vld) begin
                        pend_vld <= 1'b0;
                        if (nxt_mode == 2'b11) begin
                            mode_err <= 1'b1;
                        end else if (nxt_mode == host_mode) begin
                            done <= 1'b1;
                        end else begin
                            target    <= nxt_mode;
                            state     <= S_DRAIN;
                            busy      <= 1'b1;
                            accept_en <= 1'b0;
                            drain_to  <= 1'b0;
                            cnt       <= DRAIN_LD;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((tx_fifo_empty && !if_busy) || cnt_zero) begin
                        if (!(tx_fifo_empty && !if_busy)) drain_to <= 1'b1;
                        state       <= S_QUIESCE;
                        inactive_io <= 1'b1;
                        cnt         <= GUARD_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_QUIESCE: begin
                    if (cnt_zero) begin
                        state    <= S_CORE_RST;
                        if_reset <= 1'b1;
                        cnt      <= RST_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CORE_RST: begin
                    if (cnt_zero) begin
                        state    <= S_APPLY;
                        if_reset <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_APPLY: begin
                    host_mode <= target;
                    state     <= S_SETTLE;
                    cnt       <= GUARD_LD;
                end
                S_SETTLE: begin
                    if (cnt_zero) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        inactive_io <= 1'b0;
                        accept_en   <= 1'b1;
                        busy        <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/host_mode_seq.md
Name: host_mode_seq

Overview:
Sequencer that performs safe run-time switching of the host interface mode (SFIFO / SPI / UART) selected over I2C. It stops new host traffic, drains the TX path, idles the FTDI pins, pulses a reset into the interface cores, then applies the new host_mode. It sits between the I2C register block (mode request) and the IO-control/FIFO-mux logic, which consume its host_mode and inactive_io outputs.

Parameters:
DEF_MODE, 2'b00, host_mode value after reset (00 SFIFO, 01 SPI, 10 UART; 11 reserved)
GUARD_CYCLES, 16, cycles inactive_io is held before the core reset and after mode apply (>=1)
RST_CYCLES, 4, width of the if_reset pulse in cycles (>=1)
DRAIN_TIMEOUT, 1024, max cycles spent in DRAIN before forcing progress (>=1)
CNT_W, 16, width of the shared down-counter; must hold max(GUARD_CYCLES, RST_CYCLES, DRAIN_TIMEOUT)

Ports:
clk  in  1  system clock (SYS_CLK)
reset  in  1  synchronous, active-high reset
req_mode  in  2  requested host mode from I2C register
req_strobe  in  1  one-cycle pulse: req_mode valid
tx_fifo_empty  in  1  TX byte FIFO empty (high = nothing left to send)
if_busy  in  1  active interface core mid-frame (SPI ss_n low, UART shifting, SFIFO burst)
host_mode  out  2  applied mode to IO control, FIFO mux and cores
inactive_io  out  1  forces all FTDI pins to their inactive levels
if_reset  out  1  synchronous reset to the interface cores
accept_en  out  1  high = cores may accept new bytes from the host
busy  out  1  switch sequence in progress
done  out  1  one-cycle pulse: request completed
mode_err  out  1  one-cycle pulse: request rejected (req_mode = 11)
drain_to  out  1  sticky: last switch forced by drain timeout; cleared on next accepted request

Behaviour:
- Reset values: host_mode=DEF_MODE, inactive_io=0, if_reset=0, accept_en=1, busy=0, done=0, mode_err=0, drain_to=0, state IDLE, pending cleared, counter 0. All outputs registered.
- States: IDLE, DRAIN, QUIESCE, CORE_RST, APPLY, SETTLE, DONE.
- IDLE, req_strobe=1 at cycle T:
  - req_mode=11: mode_err=1 at T+1; stay IDLE.
  - req_mode=host_mode: done=1 at T+1; no sequence.
  - otherwise: latch target; at T+1 state=DRAIN, busy=1, accept_en=0, drain_to=0, counter=DRAIN_TIMEOUT-1.
- DRAIN: leave when tx_fifo_empty=1 and if_busy=0 are sampled in the same cycle. If the counter reaches 0 first, set drain_to=1 and leave anyway. Next state QUIESCE, inactive_io=1, counter=GUARD_CYCLES-1.
- QUIESCE: hold for GUARD_CYCLES cycles, then CORE_RST with if_reset=1 for exactly RST_CYCLES cycles.
- APPLY: lasts 1 cycle. if_reset=0; host_mode<=target, visible on the first cycle after APPLY.
- SETTLE: inactive_io stays 1 for GUARD_CYCLES cycles.
- DONE: 1 cycle. done=1, inactive_io=0, accept_en=1, busy=0 on that cycle; then IDLE.
- Latency with immediate drain: done asserted 2*GUARD_CYCLES+RST_CYCLES+3 cycles after the strobe. With defaults that is 39.
- req_strobe while busy:
  - Stored in a one-deep pending slot; latest request wins.
  - Validity is checked when the pending request is taken, not when it arrives.
  - Taken from IDLE on the cycle after DONE, with the same handling as a fresh strobe.
- req_strobe in the same cycle as DONE goes to pending.
- Counter: decrements once per cycle in timed states; each state exits when counter=0; reloaded on every state entry.
- Reset asserted mid-sequence: next cycle all outputs take their reset values, host_mode returns to DEF_MODE and pending is discarded.
- tx_fifo_empty and if_busy are ignored outside DRAIN.

Test Plan:
- Reset then idle: after reset, host_mode=00, accept_en=1, inactive_io=0, all pulses 0 for 20 cycles.
- Clean switch 00->10, tx_fifo_empty=1, if_busy=0, strobe at T:
  - busy/accept_en=0 change at T+1; inactive_io=1 at T+2.
  - if_reset high T+18..T+21; host_mode=10 at T+23.
  - done at T+39; inactive_io=0 at T+39.
- Drain wait: if_busy=1 for 100 cycles after strobe -> QUIESCE entered the cycle after if_busy falls; drain_to=0; done 100 cycles later than the clean case.
- Drain timeout: tx_fifo_empty held 0 -> after 1024 DRAIN cycles drain_to=1, sequence completes, host_mode updated; next valid request clears drain_to.
- Reject and no-op: req_mode=11 -> mode_err pulse, host_mode unchanged, busy never set. req_mode equal to current -> done the next cycle, inactive_io stays 0.
- Queued and reset: strobes 01 then 10 during an active switch -> after the first done, a second sequence ends with host_mode=10. Reset asserted during CORE_RST -> next cycle if_reset=0, host_mode=DEF_MODE, no second sequence.
